// File: rtl/cic_comb_chain.sv
// cic_comb_chain
//
// Purpose:
//   N-stage CIC comb section for the decimation path. It sits after the
//   integrator chain and the rate decimator. The design is fully synchronous
//   to clk, and in_valid qualifies every sample. Each stage is a
//   differential-delay-M comb with its own pipeline register, so the latency
//   from in_valid to out_valid is exactly STAGES clocks. Throughput is one
//   sample per clock.
//
//   All arithmetic wraps modulo 2^COMB_WIDTH. CIC filters depend on this
//   wrap-around, so nothing saturates inside the chain. The top OUT_WIDTH bits
//   of the last stage form the output.
//
// Optional feature (macro CIC_COMB_ROUND_EN):
//   When defined and COMB_WIDTH > OUT_WIDTH, the output is rounded half up
//   before it is narrowed. A positive overflow saturates to the largest
//   positive OUT_WIDTH value. When the macro is not defined, the output is
//   plain truncation toward -inf and no rounding adder exists.
//
// Parameters:
//   WIDTH       input sample width (two's complement)
//   STAGES      number of cascaded comb stages N (1..8)
//   DIFF_DELAY  differential delay M per stage (1..4)
//   GROWTH      bit growth supplied by the integrator
//   COMB_WIDTH  internal datapath width, sign bit included
//   OUT_WIDTH   output width, at most COMB_WIDTH
//
// Ports:
//   clk        system clock; all state updates on posedge
//   rst        synchronous reset, active low
//   in_valid   input sample strobe (may be high on consecutive cycles)
//   in_data    signed input sample, WIDTH bits
//   out_valid  output sample qualifier
//   out_data   signed comb output, OUT_WIDTH bits; holds between pulses
//   primed     sticky flag, high once the start-up transient has flushed

module cic_comb_chain #(
  parameter int WIDTH      = 16,
  parameter int STAGES     = 3,
  parameter int DIFF_DELAY = 1,
  parameter int GROWTH     = 7,
  parameter int COMB_WIDTH = WIDTH + GROWTH + 1,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        primed
);

  localparam int PRIME_COUNT = STAGES * DIFF_DELAY;
  localparam int CNT_W       = $clog2(PRIME_COUNT + 1);
  localparam int DROP        = COMB_WIDTH - OUT_WIDTH;
  localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(PRIME_COUNT);

  // Parameter sanity checks, reported at elaboration time
  if (OUT_WIDTH > COMB_WIDTH || OUT_WIDTH < 1) begin : g_err_out_width
    $error("cic_comb_chain: OUT_WIDTH (%0d) must be in 1..COMB_WIDTH (%0d)",
           OUT_WIDTH, COMB_WIDTH);
  end
  if (STAGES < 1 || STAGES > 8) begin : g_err_stages
    $error("cic_comb_chain: STAGES (%0d) must be in 1..8", STAGES);
  end
  if (DIFF_DELAY < 1 || DIFF_DELAY > 4) begin : g_err_diff_delay
    $error("cic_comb_chain: DIFF_DELAY (%0d) must be in 1..4", DIFF_DELAY);
  end
  if (COMB_WIDTH < WIDTH) begin : g_err_comb_width
    $error("cic_comb_chain: COMB_WIDTH (%0d) must be >= WIDTH (%0d)",
           COMB_WIDTH, WIDTH);
  end

  logic signed [COMB_WIDTH-1:0] stage_in  [STAGES];
  logic signed [COMB_WIDTH-1:0] stage_out [STAGES];
  logic signed [COMB_WIDTH-1:0] taps      [STAGES][DIFF_DELAY];
  logic [STAGES-1:0]            stage_valid;
  logic [STAGES-1:0]            valid_pipe;
  logic [CNT_W-1:0]             prime_cnt;
  logic signed [COMB_WIDTH-1:0] y_last;
  logic [OUT_WIDTH-1:0]         reduced;

  // Connect the stages. Stage 0 takes the sign-extended input sample and
  // in_valid. Every later stage takes the register and valid of the stage
  // in front of it.
  always_comb begin
    stage_in[0]    = COMB_WIDTH'(in_data);
    stage_valid[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      stage_in[s]    = stage_out[s-1];
      stage_valid[s] = valid_pipe[s-1];
    end
  end

  // Comb datapath. A stage advances only when a valid sample reaches it.
  // The delay line then shifts, and the stage register takes
  // x - x[n-M] with modular wrap. Without a valid sample, everything holds.
  // The valid pipeline advances every cycle, so gaps in the input stream
  // propagate unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_pipe <= '0;
      for (int s = 0; s < STAGES; s++) begin
        stage_out[s] <= '0;
        for (int k = 0; k < DIFF_DELAY; k++) begin
          taps[s][k] <= '0;
        end
      end
    end else begin
      valid_pipe <= stage_valid;
      for (int s = 0; s < STAGES; s++) begin
        if (stage_valid[s]) begin
          stage_out[s] <= stage_in[s] - taps[s][DIFF_DELAY-1];
          taps[s][0]   <= stage_in[s];
          for (int k = 1; k < DIFF_DELAY; k++) begin
            taps[s][k] <= taps[s][k-1];
          end
        end
      end
    end
  end

  assign y_last = stage_out[STAGES-1];

  // Output narrowing. The last stage register is the output register, so
  // the rounding adder (when present) adds no latency.
`ifdef CIC_COMB_ROUND_EN
  if (DROP > 0) begin : g_round
    localparam logic [COMB_WIDTH-1:0] HALF    = COMB_WIDTH'(1) << (DROP - 1);
    localparam logic [OUT_WIDTH-1:0]  OUT_MAX = ~(OUT_WIDTH'(1) << (OUT_WIDTH - 1));
    logic [COMB_WIDTH-1:0] rounded;
    logic                  overflow;

    // Adding a positive constant can only overflow from a non-negative
    // value into the sign bit. That case is clamped to the positive limit.
    always_comb begin
      rounded  = $unsigned(y_last) + HALF;
      overflow = ~y_last[COMB_WIDTH-1] & rounded[COMB_WIDTH-1];
      reduced  = overflow ? OUT_MAX : rounded[COMB_WIDTH-1 -: OUT_WIDTH];
    end
  end else begin : g_pass
    assign reduced = y_last[COMB_WIDTH-1 -: OUT_WIDTH];
  end
`else
  assign reduced = y_last[COMB_WIDTH-1 -: OUT_WIDTH];
`endif

  assign out_data  = $signed(reduced);
  assign out_valid = valid_pipe[STAGES-1];

  // Prime counter. It counts the samples that reach the last stage and stops
  // at STAGES*DIFF_DELAY. The sample that arrives once the count is full is
  // output index STAGES*DIFF_DELAY, and primed is set together with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (stage_valid[STAGES-1]) begin
      if (prime_cnt == PRIME_MAX) begin
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain
//
// Drives six differently configured cic_comb_chain instances from one shared
// stimulus stream. For every accepted sample, a binomial-sum reference
// (sum of (-1)^k C(N,k) x[n-kM], wrapped and narrowed) supplies the
// expected value. A single compare process checks out_valid, out_data and
// primed of every instance on every cycle. Directed phases pin the reference
// with hand-computed literals.
//
// Instance configurations (index: STAGES, M, WIDTH, COMB_WIDTH, OUT_WIDTH):
//   0: 3,1,16,24,16   1: 1,2,16,24,24   2: 1,1,16,17,17
//   3: 1,1,16,24,24   4: 1,1,24,24,16   5: 3,1,16,24,24

module tb_cic_comb_chain;

  localparam int NI   = 6;
  localparam int HMAX = 8192;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_data_w;

  logic [NI-1:0] ov;
  logic [NI-1:0] pr;
  logic signed [15:0] od_a;
  logic signed [23:0] od_b;
  logic signed [16:0] od_c;
  logic signed [23:0] od_d;
  logic signed [15:0] od_e;
  logic signed [23:0] od_f;
  logic signed [63:0] od_l [NI];

  int cfg_s  [NI] = '{3, 1, 1, 1, 1, 3};
  int cfg_m  [NI] = '{1, 2, 1, 1, 1, 1};
  int cfg_w  [NI] = '{16, 16, 16, 16, 24, 16};
  int cfg_cw [NI] = '{24, 24, 17, 24, 24, 24};
  int cfg_ow [NI] = '{16, 24, 17, 24, 16, 24};

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          cyc  = 0;
  int          hlen = 0;
  logic [23:0] hist   [HMAX];
  bit          rec_v  [HMAX];
  bit          rec_rst[HMAX];
  longint      rec_d  [HMAX][NI];
  longint      exp_d  [NI];
  int          out_cnt[NI];

  cic_comb_chain #(.STAGES(3), .DIFF_DELAY(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data_w[15:0]),
    .out_valid(ov[0]), .out_data(od_a), .primed(pr[0]));

  cic_comb_chain #(.STAGES(1), .DIFF_DELAY(2), .OUT_WIDTH(24)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data_w[15:0]),
    .out_valid(ov[1]), .out_data(od_b), .primed(pr[1]));

  cic_comb_chain #(.STAGES(1), .DIFF_DELAY(1), .GROWTH(0), .OUT_WIDTH(17)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data_w[15:0]),
    .out_valid(ov[2]), .out_data(od_c), .primed(pr[2]));

  cic_comb_chain #(.STAGES(1), .DIFF_DELAY(1), .OUT_WIDTH(24)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data_w[15:0]),
    .out_valid(ov[3]), .out_data(od_d), .primed(pr[3]));

  cic_comb_chain #(.WIDTH(24), .STAGES(1), .DIFF_DELAY(1), .GROWTH(0),
                   .COMB_WIDTH(24), .OUT_WIDTH(16)) u_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data_w),
    .out_valid(ov[4]), .out_data(od_e), .primed(pr[4]));

  cic_comb_chain #(.STAGES(3), .DIFF_DELAY(1), .OUT_WIDTH(24)) u_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data_w[15:0]),
    .out_valid(ov[5]), .out_data(od_f), .primed(pr[5]));

  always_comb begin
    od_l[0] = od_a;
    od_l[1] = od_b;
    od_l[2] = od_c;
    od_l[3] = od_d;
    od_l[4] = od_e;
    od_l[5] = od_f;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int j = 1; j <= k; j++) r = r * (n - k + j) / j;
    return r;
  endfunction

  function automatic longint sext(input logic [23:0] raw, input int w);
    longint one = 1;
    longint v = longint'(raw) & ((one << w) - 1);
    if (v >= (one << (w - 1))) v = v - (one << w);
    return v;
  endfunction

  // Expected narrowed output for the newest sample in hist, for instance i
  function automatic longint model_out(input int i);
    longint one = 1;
    longint acc = 0;
    longint term;
    int idx;
    int d;
    for (int k = 0; k <= cfg_s[i]; k++) begin
      idx = hlen - 1 - k * cfg_m[i];
      if (idx >= 0) begin
        term = binom(cfg_s[i], k) * sext(hist[idx], cfg_w[i]);
        acc  = (k % 2 == 1) ? acc - term : acc + term;
      end
    end
    acc = acc & ((one << cfg_cw[i]) - 1);
    if (acc >= (one << (cfg_cw[i] - 1))) acc = acc - (one << cfg_cw[i]);
    d = cfg_cw[i] - cfg_ow[i];
`ifdef CIC_COMB_ROUND_EN
    if (d > 0) begin
      if (acc + (one << (d - 1)) > (one << (cfg_cw[i] - 1)) - 1)
        return (one << (cfg_ow[i] - 1)) - 1;
      acc = acc + (one << (d - 1));
    end
`endif
    return acc >>> d;
  endfunction

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [23:0] d, input bit rn);
    @(negedge clk);
    rst       = rn;
    in_valid  = v;
    in_data_w = d;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 24'd0, 1'b0);
    applyStimulus(1'b0, 24'd0, 1'b0);
  endtask

  // Constant input 100 into the 3-stage full-width instance
  task automatic runConstant(input string tag);
    longint exp_seq [6] = '{100, -200, 100, 0, 0, 0};
    int j;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 6, 24'd100, 1'b1);
      j = i - 3;
      if (j >= 0 && j < 6) begin
        checkOutput($sformatf("%s out%0d", tag, j), od_l[5], exp_seq[j]);
        checkOutput($sformatf("%s valid%0d", tag, j), {63'd0, ov[5]}, 1);
        checkOutput($sformatf("%s primed%0d", tag, j), {63'd0, pr[5]}, (j >= 3) ? 1 : 0);
      end else if (j == 6) begin
        checkOutput($sformatf("%s idle valid", tag), {63'd0, ov[5]}, 0);
      end
    end
  endtask

  // Reference: record what every instance accepts on each clock edge
  always @(posedge clk) begin
    cyc++;
    if (cyc < HMAX) begin
      if (!rst) begin
        rec_rst[cyc] = 1'b1;
        rec_v[cyc]   = 1'b0;
        hlen         = 0;
      end else begin
        rec_rst[cyc] = 1'b0;
        rec_v[cyc]   = in_valid;
        if (in_valid) begin
          hist[hlen] = in_data_w;
          hlen++;
          for (int i = 0; i < NI; i++) rec_d[cyc][i] = model_out(i);
        end
      end
    end
  end

  // Compare every instance against the reference on every cycle
  always @(posedge clk) begin
    #1;
    if (cyc >= 1 && cyc < HMAX) begin
      for (int i = 0; i < NI; i++) begin
        int c;
        bit ev;
        c  = cyc - cfg_s[i] + 1;
        ev = 1'b0;
        if (c >= 1 && rec_v[c]) begin
          ev = 1'b1;
          for (int r = c + 1; r <= cyc; r++) if (rec_rst[r]) ev = 1'b0;
        end
        if (rec_rst[cyc]) begin
          exp_d[i]   = 0;
          out_cnt[i] = 0;
        end
        if (ev) begin
          exp_d[i] = rec_d[c][i];
          out_cnt[i]++;
        end
        checkOutput($sformatf("inst%0d valid", i), {63'd0, ov[i]}, ev ? 1 : 0);
        checkOutput($sformatf("inst%0d data", i), od_l[i], exp_d[i]);
        checkOutput($sformatf("inst%0d primed", i), {63'd0, pr[i]},
                    (out_cnt[i] > cfg_s[i] * cfg_m[i]) ? 1 : 0);
      end
    end
  end

  initial begin
    longint exp3 [4] = '{1, 2, 2, 2};
    longint exp384;
`ifdef CIC_COMB_ROUND_EN
    exp384 = 2;
`else
    exp384 = 1;
`endif
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data_w = 24'd0;
    for (int i = 0; i < NI; i++) begin
      exp_d[i]   = 0;
      out_cnt[i] = 0;
    end

    // reset state
    doReset();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset valid%0d", i), {63'd0, ov[i]}, 0);
      checkOutput($sformatf("reset data%0d", i), od_l[i], 0);
      checkOutput($sformatf("reset primed%0d", i), {63'd0, pr[i]}, 0);
    end

    // single stage, M=1: 5,7,7 -> 5,2,0
    applyStimulus(1'b1, 24'd5, 1'b1);
    applyStimulus(1'b1, 24'd7, 1'b1);
    checkOutput("t1 out0", od_l[3], 5);
    checkOutput("t1 valid0", {63'd0, ov[3]}, 1);
    checkOutput("t1 primed0", {63'd0, pr[3]}, 0);
    applyStimulus(1'b1, 24'd7, 1'b1);
    checkOutput("t1 out1", od_l[3], 2);
    checkOutput("t1 primed1", {63'd0, pr[3]}, 1);
    applyStimulus(1'b0, 24'd0, 1'b1);
    checkOutput("t1 out2", od_l[3], 0);
    applyStimulus(1'b0, 24'd0, 1'b1);
    checkOutput("t1 idle valid", {63'd0, ov[3]}, 0);

    // three stages, constant input
    doReset();
    runConstant("t2");

    // single stage, M=2, input every third cycle
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i % 3 == 0, 24'(i / 3 + 1), 1'b1);
      if (i >= 1) begin
        checkOutput($sformatf("t3 valid c%0d", i), {63'd0, ov[1]}, ((i - 1) % 3 == 0) ? 1 : 0);
        checkOutput($sformatf("t3 data c%0d", i), od_l[1], exp3[(i - 1) / 3]);
      end
    end

    // full-scale steps
    doReset();
    applyStimulus(1'b1, 24'h008000, 1'b1);
    applyStimulus(1'b1, 24'h007FFF, 1'b1);
    checkOutput("t4 neg full", od_l[3], -32768);
    applyStimulus(1'b0, 24'd0, 1'b1);
    checkOutput("t4 step 65535", od_l[3], 65535);
    doReset();
    applyStimulus(1'b1, 24'h007FFF, 1'b1);
    applyStimulus(1'b1, 24'h008000, 1'b1);
    checkOutput("t4 cw17 first", od_l[2], 32767);
    applyStimulus(1'b0, 24'd0, 1'b1);
    checkOutput("t4 cw17 step", od_l[2], -65535);

    // output narrowing
    doReset();
    applyStimulus(1'b1, 24'd384, 1'b1);
    applyStimulus(1'b0, 24'd0, 1'b1);
    checkOutput("t5 narrow 384", od_l[4], exp384);
    doReset();
    applyStimulus(1'b1, 24'h7FFFFF, 1'b1);
    applyStimulus(1'b0, 24'd0, 1'b1);
    checkOutput("t5 narrow max", od_l[4], 32767);

    // reset while two samples are in flight
    doReset();
    applyStimulus(1'b1, 24'd100, 1'b1);
    applyStimulus(1'b1, 24'd100, 1'b1);
    applyStimulus(1'b0, 24'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 24'd0, 1'b1);
      checkOutput($sformatf("t6 flushed valid c%0d", i), {63'd0, ov[5]}, 0);
      checkOutput($sformatf("t6 flushed primed c%0d", i), {63'd0, pr[5]}, 0);
    end
    runConstant("t6");

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, 24'($urandom() & 32'h00FFFFFF),
                    $urandom_range(0, 199) != 0);
    end
    for (int n = 0; n < 6; n++) applyStimulus(1'b0, 24'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
